// File: rtl/cell_pos_reader.sv
// cell_pos_reader
//   Read-side sequencer for one cell position memory. A start pulse reads
//   address 0 to fetch the particle count (clamped to PARTICLE_NUM-1), then
//   streams addresses 1..N through a 4-entry output FIFO with valid/ready
//   flow control. The memory has a fixed 2-cycle read latency.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle request, ignored while busy
//   busy, done        sequence in progress / one-cycle completion pulse
//   particle_num      clamped count latched from address 0
//   mem_address       registered memory address
//   mem_rden          registered read enable
//   mem_wren          tied low
//   mem_q             memory read data, valid 2 cycles after address/rden
//   out_valid         out_data/out_id valid (FIFO head)
//   out_ready         downstream accept
//   out_data          particle position word {posz, posy, posx}
//   out_id            particle address 1..N
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_num,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FIN
  } state_e;

  state_e                  state_q, state_d;
  logic                    mem_rden_q, mem_rden_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]   pnum_q, pnum_d;
  logic                    cnt_wait_q, cnt_wait_d;

  // In-flight tracker: stage 0 holds the read issued last cycle, stage 1
  // the read whose data is on mem_q this cycle.
  logic [1:0]              tag_v_q;
  logic [ADDR_WIDTH-1:0]   tag_addr_q [2];

  logic [DATA_WIDTH-1:0]   fifo_data_q [4];
  logic [ADDR_WIDTH-1:0]   fifo_id_q   [4];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              fifo_cnt_q, fifo_cnt_d;

  logic                    push, pop, credit_ok;
  logic [ADDR_WIDTH-1:0]   cnt_raw, cnt_clamped;

  assign push      = tag_v_q[1];
  assign pop       = out_valid & out_ready;
  assign out_valid = (fifo_cnt_q != 3'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_id    = fifo_id_q[rd_ptr_q];

  assign fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);

  // Credit is evaluated against the state after this edge: the read on the
  // bus now and the one in stage 0 are still outstanding, while the stage-1
  // return is already counted in fifo_cnt_d. Keeping the total below 4
  // guarantees every issued read has a FIFO slot when it lands.
  assign credit_ok = ((3'(mem_rden_q) + 3'(tag_v_q[0]) + fifo_cnt_d) < 3'd4);

  assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

  assign busy         = (state_q == RD_CNT) || (state_q == WAIT_CNT) ||
                        (state_q == STREAM) || (state_q == DRAIN);
  assign done         = (state_q == FIN);
  assign particle_num = pnum_q;
  assign mem_address  = mem_addr_q;
  assign mem_rden     = mem_rden_q;
  assign mem_wren     = 1'b0;

  always_comb begin
    state_d     = state_q;
    mem_rden_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    next_addr_d = next_addr_q;
    pnum_d      = pnum_q;
    cnt_wait_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_CNT;
          mem_rden_d = 1'b1;
          mem_addr_d = '0;
        end
      end
      RD_CNT: state_d = WAIT_CNT;
      WAIT_CNT: begin
        if (!cnt_wait_q) begin
          cnt_wait_d = 1'b1;
        end else begin
          pnum_d = cnt_clamped;
          if (cnt_clamped == '0) begin
            state_d = FIN;
          end else begin
            // Address 1 is issued on the transition so it is on the bus in
            // the first streaming cycle; a single particle is already fully
            // issued, so it goes straight to draining.
            mem_rden_d  = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(1);
            next_addr_d = ADDR_WIDTH'(2);
            state_d     = (cnt_clamped == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        if (credit_ok) begin
          mem_rden_d  = 1'b1;
          mem_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (next_addr_q == pnum_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_rden_q && !tag_v_q[0] && (fifo_cnt_d == 3'd0)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_rden_q  <= 1'b0;
      mem_addr_q  <= '0;
      next_addr_q <= '0;
      pnum_q      <= '0;
      cnt_wait_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rden_q  <= mem_rden_d;
      mem_addr_q  <= mem_addr_d;
      next_addr_q <= next_addr_d;
      pnum_q      <= pnum_d;
      cnt_wait_q  <= cnt_wait_d;
    end
  end

  // Address 0 is the count read and is never tagged for the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q       <= '0;
      tag_addr_q[0] <= '0;
      tag_addr_q[1] <= '0;
    end else begin
      tag_v_q[0]    <= mem_rden_q && (mem_addr_q != '0);
      tag_addr_q[0] <= mem_addr_q;
      tag_v_q[1]    <= tag_v_q[0];
      tag_addr_q[1] <= tag_addr_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_q;
        fifo_id_q[wr_ptr_q]   <= tag_addr_q[1];
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_cell_pos_reader.sv
// tb_cell_pos_reader
//   Directed bench for cell_pos_reader: a 2-cycle-latency memory model,
//   per-run cycle-indexed monitoring, and hand-computed expectations.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, mem_rden, mem_wren, out_valid;
  logic [AW-1:0] particle_num, mem_address, out_id;
  logic [DW-1:0] mem_q, out_data;

  always #5 clk = ~clk;

  cell_pos_reader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PARTICLE_NUM(PN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .particle_num(particle_num),
    .mem_address (mem_address),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id)
  );

  // Memory model: address sampled at an edge, data on mem_q two cycles
  // after the address was presented.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] mem_p1 = '0;
  initial mem_q = '0;
  always @(posedge clk) begin
    mem_p1 <= mem[mem_address];
    mem_q  <= mem_p1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int wren_hits = 0;
  always @(negedge clk) if (mem_wren !== 1'b0) wren_hits++;

  int hs_n, hs_first, hs_last, last_id, order_err, stable_err;
  int done_n, done_cyc, busy_n, busy_last, max_addr, max_out, issued;

  // Starts a sequence (start sampled at edge E0) and monitors cycles 1..max_cyc
  // at the falling edge. stall_len: out_ready held low for that many cycles
  // starting with the first out_valid cycle. extra_start: cycle in which a
  // stray start pulse is driven (0 = none).
  task automatic run(input int stall_len, input int extra_start,
                     input bit stop_on_done, input int max_cyc);
    int fv;
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [AW-1:0] pid;
    int            exp_id;
    hs_n = 0; hs_first = 0; hs_last = 0; last_id = 0; order_err = 0;
    stable_err = 0; done_n = 0; done_cyc = 0; busy_n = 0; busy_last = 0;
    max_addr = 0; max_out = 0; issued = 0; fv = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pid = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= max_cyc; t++) begin
      @(negedge clk);
      start = (t == extra_start);
      if (fv == 0 && out_valid) fv = t;
      out_ready = !(stall_len > 0 && fv != 0 && t < fv + stall_len);
      if (busy) begin busy_n++; busy_last = t; end
      if (mem_rden) begin
        if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
        if (mem_address != '0) issued++;
      end
      if (issued - hs_n > max_out) max_out = issued - hs_n;
      if (pv && !pr && (!out_valid || out_data !== pd || out_id !== pid)) stable_err++;
      if (out_valid && out_ready) begin
        exp_id = hs_n + 1;
        if (int'(out_id) != exp_id || out_data !== mem[exp_id]) order_err++;
        if (hs_n == 0) hs_first = t;
        hs_last = t;
        last_id = int'(out_id);
        hs_n++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pid = out_id;
      if (done) begin
        if (done_n == 0) done_cyc = t;
        done_n++;
        if (stop_on_done) break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int stale;
    for (int i = 0; i < 256; i++)
      mem[i] = {32'(i * 7 + 3), 32'h00A5_0000 | 32'(i), 32'(1000 + i)};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, particle_num, mem_address, mem_rden, mem_wren, out_valid, out_data, out_id},
          '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Count 3, out_ready high
    mem[0] = 96'd3;
    run(0, 0, 1'b0, 20);
    check("c3_first_valid", hs_first, 7);
    check("c3_last_hs", hs_last, 9);
    check("c3_n", hs_n, 3);
    check("c3_order", order_err, 0);
    check("c3_done_cyc", done_cyc, 10);
    check("c3_done_n", done_n, 1);
    check("c3_pnum", particle_num, 3);

    // Count 5 with a 6-cycle stall at the first valid
    mem[0] = 96'd5;
    run(6, 0, 1'b0, 40);
    check("c5_n", hs_n, 5);
    check("c5_order", order_err, 0);
    check("c5_stable", stable_err, 0);
    check("c5_max_outstanding", max_out, 4);
    check("c5_done_n", done_n, 1);
    check("c5_done_after_last", done_cyc, hs_last + 1);

    // Count 0
    mem[0] = 96'd0;
    run(0, 0, 1'b0, 12);
    check("c0_n", hs_n, 0);
    check("c0_done_cyc", done_cyc, 4);
    check("c0_done_n", done_n, 1);
    check("c0_busy_cycles", busy_n, 3);
    check("c0_busy_last", busy_last, 3);
    check("c0_pnum", particle_num, 0);

    // Count field 250 clamps to 219
    mem[0] = 96'd250;
    run(0, 0, 1'b0, 240);
    check("clamp_pnum", particle_num, 219);
    check("clamp_last_id", last_id, 219);
    check("clamp_max_addr", max_addr, 219);
    check("clamp_n", hs_n, 219);
    check("clamp_order", order_err, 0);
    check("clamp_done_cyc", done_cyc, 226);

    // Stray start during STREAM
    mem[0] = 96'd3;
    run(0, 5, 1'b0, 24);
    check("restart_first", hs_first, 7);
    check("restart_n", hs_n, 3);
    check("restart_order", order_err, 0);
    check("restart_done_cyc", done_cyc, 10);
    check("restart_done_n", done_n, 1);

    // Back-to-back: start in the cycle right after done
    run(0, 0, 1'b1, 20);
    check("b2b_a_done_cyc", done_cyc, 10);
    run(0, 0, 1'b0, 20);
    check("b2b_b_first", hs_first, 7);
    check("b2b_b_done_cyc", done_cyc, 10);
    check("b2b_b_n", hs_n, 3);

    // Reset during STREAM with two reads in flight
    mem[0] = 96'd5;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_rden_before", mem_rden, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          {busy, done, particle_num, mem_address, mem_rden, mem_wren, out_valid, out_data, out_id},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (out_valid || done || busy) stale++;
    end
    check("rst_stale_ignored", stale, 0);
    run(0, 0, 1'b0, 20);
    check("rst_fresh_n", hs_n, 5);
    check("rst_fresh_order", order_err, 0);
    check("rst_fresh_done_cyc", done_cyc, 12);
    check("rst_fresh_pnum", particle_num, 5);

    check("wren_never", wren_hits, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
